// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and byte width for the SPI master.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  localparam int SPI_WIDTH = 8;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: emits a one-cycle tick every DIV enabled cycles; restart holds the count at zero.
module spi_clk_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic restart,
  output logic tick
);
  logic [7:0] cnt_q, cnt_d;
  assign tick = ena && !restart && cnt_q == 8'(DIV - 1);
  always_comb cnt_d = restart ? '0 : !ena ? cnt_q : tick ? '0 : cnt_q + 8'd1;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI byte master, MSB first, sclk half-period DIV clk cycles.
// Defining SPI_MASTER_BURST_EN lets a start in the last HOLD cycle chain the next byte with ss held low.
module spi_master import spi_pkg::*; #(
  parameter int DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 start,
  input  logic [SPI_WIDTH-1:0] data_in,
  output logic [SPI_WIDTH-1:0] data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 ss
);
  state_t state_q, state_d;
  logic [SPI_WIDTH-1:0] sh_q, sh_d, dout_q, dout_d;
  logic [2:0] bit_q, bit_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, ss_q, ss_d, busy_q, busy_d, done_q, done_d;
  logic tick, burst;
`ifdef SPI_MASTER_BURST_EN
  assign burst = start;
`else
  assign burst = 1'b0;
`endif
  spi_clk_div #(.DIV(DIV)) u_div (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .restart (state_q == IDLE),
    .tick    (tick)
  );
  // One shift register serves both directions: miso enters at bit 0 as the next mosi bit reaches bit 7.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (ena && start) begin
        state_d = SETUP;
        sh_d    = data_in;
        mosi_d  = data_in[SPI_WIDTH-1];
        bit_d   = '0;
        ss_d    = 1'b0;
        busy_d  = 1'b1;
      end
      SETUP: if (tick) begin
        state_d = XFER;
        sclk_d  = 1'b1;
        sh_d    = {sh_q[SPI_WIDTH-2:0], miso};
      end
      XFER: if (tick) begin
        if (sclk_q) begin
          sclk_d = 1'b0;
          mosi_d = sh_q[SPI_WIDTH-1];
        end else if (bit_q == 3'(SPI_WIDTH - 1)) state_d = HOLD;
        else begin
          sclk_d = 1'b1;
          sh_d   = {sh_q[SPI_WIDTH-2:0], miso};
          bit_d  = bit_q + 3'd1;
        end
      end
      HOLD: if (tick) begin
        dout_d = sh_q;
        done_d = 1'b1;
        if (burst) begin
          state_d = SETUP;
          sh_d    = data_in;
          mosi_d  = data_in[SPI_WIDTH-1];
          bit_d   = '0;
        end else begin
          state_d = IDLE;
          mosi_d  = 1'b0;
          ss_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      dout_q  <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign data_out = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ss       = ss_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed vectors for spi_master at DIV=2 and DIV=1 with a mode-0 slave model.
module tb_spi_master;
  logic clk = 0, rst = 1, ena = 1, start2 = 0, start1 = 0;
  logic [7:0] din = 0;
  logic sclk2, mosi2, ss2, busy2, done2, miso2, sclk1, mosi1, ss1, busy1, done1, miso1;
  logic [7:0] dout2, dout1;
  always #5 clk = ~clk;

  spi_master #(.DIV(2)) u2 (.clk(clk), .rst(rst), .ena(ena), .start(start2), .data_in(din),
    .data_out(dout2), .busy(busy2), .done(done2), .sclk(sclk2), .mosi(mosi2), .miso(miso2), .ss(ss2));
  spi_master #(.DIV(1)) u1 (.clk(clk), .rst(rst), .ena(ena), .start(start1), .data_in(din),
    .data_out(dout1), .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .miso(miso1), .ss(ss1));

  // Slave models: present the next reply bit after each sclk fall, capture mosi on each sclk rise.
  logic [7:0] sb2 = 0, sb1 = 0, cap2 = 0, cap1 = 0, sh2, sh1;
  logic loop2 = 0, ps2 = 0, ps1 = 0;
  int idx2 = 0, idx1 = 0, rise2 = 0, rise1 = 0, ssl1 = 0, dn2 = 0;
  assign sh2 = sb2 << idx2;
  assign sh1 = sb1 << idx1;
  assign miso2 = loop2 ? mosi2 : sh2[7];
  assign miso1 = sh1[7];
  always @(negedge clk) begin
    if (!ps2 && sclk2) begin
      cap2  <= {cap2[6:0], mosi2};
      rise2 <= rise2 + 1;
    end
    idx2 <= ss2 ? 0 : (ps2 && !sclk2) ? idx2 + 1 : idx2;
    dn2  <= dn2 + int'(done2);
    ps2  <= sclk2;
  end
  always @(negedge clk) begin
    if (!ps1 && sclk1) begin
      cap1  <= {cap1[6:0], mosi1};
      rise1 <= rise1 + 1;
    end
    idx1 <= ss1 ? 0 : (ps1 && !sclk1) ? idx1 + 1 : idx1;
    ssl1 <= ssl1 + int'(!ss1);
    ps1  <= sclk1;
  end

  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic go2(input logic [7:0] d);
    @(negedge clk);
    din = d;
    start2 = 1;
    @(negedge clk);
    start2 = 0;
  endtask

  task automatic wait2(inout int lat);
    while (done2 !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] sb;
    logic       loop;
    logic [7:0] dout;
    logic [7:0] mo;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int lat, r0, d0, s0;
    logic s, m, q, frz, sshi;
    tbl[0] = '{8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5};
    tbl[1] = '{8'h3C, 8'hC3, 1'b0, 8'hC3, 8'h3C};
    tbl[2] = '{8'h00, 8'hFF, 1'b0, 8'hFF, 8'h00};
    tbl[3] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF};
    tbl[4] = '{8'h81, 8'h5A, 1'b0, 8'h5A, 8'h81};
    repeat (3) @(negedge clk);
    chk("rst_ss", ss2, 1);
    chk("rst_sclk", sclk2, 0);
    chk("rst_mosi", mosi2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_dout", dout2, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      sb2 = tbl[i].sb;
      loop2 = tbl[i].loop;
      r0 = rise2;
      d0 = dn2;
      go2(tbl[i].din);
      chk("busy_after_start", busy2, 1);
      chk("ss_after_start", ss2, 0);
      chk("mosi_first_bit", mosi2, tbl[i].din[7]);
      lat = 1;
      wait2(lat);
      chk("latency", lat, 37);
      chk("data_out", dout2, tbl[i].dout);
      chk("ss_at_done", ss2, 1);
      chk("busy_at_done", busy2, 0);
      @(negedge clk);
      chk("done_single", done2, 0);
      chk("mosi_idle", mosi2, 0);
      chk("mosi_bits", cap2, tbl[i].mo);
      chk("sclk_rises", rise2 - r0, 8);
      chk("done_count", dn2 - d0, 1);
    end
    // DIV=1 transfer: latency 19, ss low for 18 cycles
    sb1 = 8'hC3;
    r0 = rise1;
    s0 = ssl1;
    @(negedge clk);
    din = 8'h3C;
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    lat = 1;
    while (done1 !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("div1_latency", lat, 19);
    chk("div1_data_out", dout1, 8'hC3);
    @(negedge clk);
    chk("div1_mosi_bits", cap1, 8'h3C);
    chk("div1_rises", rise1 - r0, 8);
    chk("div1_ss_low", ssl1 - s0, 18);
    // start while busy is ignored
    sb2 = 8'h66;
    loop2 = 0;
    d0 = dn2;
    go2(8'h99);
    lat = 1;
    for (int b = 1; b < 5; b++) begin
      @(negedge clk);
      lat++;
    end
    din = 8'hFF;
    start2 = 1;
    @(negedge clk);
    lat++;
    start2 = 0;
    wait2(lat);
    chk("busy_start_latency", lat, 37);
    chk("busy_start_dout", dout2, 8'h66);
    @(negedge clk);
    chk("busy_start_mosi", cap2, 8'h99);
    repeat (60) @(negedge clk);
    chk("busy_start_dones", dn2 - d0, 1);
    chk("busy_start_idle", busy2, 0);
    // reset after the 3rd sclk rise
    r0 = rise2;
    go2(8'hC5);
    lat = 0;
    while (rise2 - r0 < 3 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    d0 = dn2;
    rst = 1;
    @(negedge clk);
    chk("midrst_ss", ss2, 1);
    chk("midrst_sclk", sclk2, 0);
    chk("midrst_busy", busy2, 0);
    chk("midrst_mosi", mosi2, 0);
    chk("midrst_dout", dout2, 0);
    rst = 0;
    repeat (60) @(negedge clk);
    chk("midrst_no_done", dn2 - d0, 0);
    sb2 = 8'h4B;
    go2(8'h2D);
    lat = 1;
    wait2(lat);
    chk("postrst_latency", lat, 37);
    chk("postrst_dout", dout2, 8'h4B);
    // ena low for 10 cycles mid-XFER
    sb2 = 8'h96;
    r0 = rise2;
    go2(8'h69);
    lat = 1;
    while (rise2 - r0 < 2 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    ena = 0;
    s = sclk2;
    m = mosi2;
    q = ss2;
    frz = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (sclk2 !== s || mosi2 !== m || ss2 !== q || done2 !== 1'b0) frz = 0;
    end
    ena = 1;
    chk("ena_frozen", frz, 1);
    wait2(lat);
    chk("ena_latency", lat, 47);
    chk("ena_dout", dout2, 8'h96);
    @(negedge clk);
    chk("ena_mosi", cap2, 8'h69);
    // start held through the first byte's final HOLD cycle
    loop2 = 1;
    @(negedge clk);
    din = 8'h12;
    start2 = 1;
    @(negedge clk);
    din = 8'h34;
    lat = 1;
    wait2(lat);
    start2 = 0;
    chk("burst_first_latency", lat, 37);
    chk("burst_first_dout", dout2, 8'h12);
`ifdef SPI_MASTER_BURST_EN
    chk("burst_ss_held", ss2, 0);
    chk("burst_busy_held", busy2, 1);
    sshi = 0;
    @(negedge clk);
    lat = 1;
    while (done2 !== 1'b1 && lat < 400) begin
      if (ss2) sshi = 1;
      @(negedge clk);
      lat++;
    end
    chk("burst_gap", lat, 36);
    chk("burst_second_dout", dout2, 8'h34);
    chk("burst_ss_never_high", sshi, 0);
`else
    chk("single_ss_release", ss2, 1);
    chk("single_busy_release", busy2, 0);
    repeat (5) @(negedge clk);
    chk("single_no_chain", busy2, 0);
`endif
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
